// File: rtl/mod_ctrl.sv
// Sequential restoring divider for the Lab08 MOD datapath: one quotient bit per clock,
// returning remainder (primary result), quotient and a divide-by-zero flag via start/done.
module mod_ctrl #(
   parameter int unsigned WIDTH = 8
) (
   input  logic             clk,
   input  logic             clr,
   input  logic             start,
   input  logic [WIDTH-1:0] dividend,
   input  logic [WIDTH-1:0] divisor,
   output logic             busy,
   output logic             done,
   output logic             err,
   output logic [WIDTH-1:0] remainder,
   output logic [WIDTH-1:0] quotient
);

   localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

   typedef enum logic [1:0] {
      S_IDLE,
      S_LOAD,
      S_RUN,
      S_DONE
   } state_t;

   state_t           state;
   logic [WIDTH-1:0] d_q;
   logic [WIDTH-1:0] q_q;
   logic [WIDTH-1:0] r_q;
   logic [CW-1:0]    cnt;

   logic [WIDTH:0]   t_c;
   logic             ge_c;
   logic [WIDTH-1:0] diff_c;
   logic [WIDTH-1:0] r_nxt_c;
   logic [WIDTH-1:0] q_nxt_c;

   // One restoring step. R < D always holds after a step, so the top bit of the
   // (WIDTH+1)-bit partial remainder is always 0 and is not stored.
   always_comb begin
      t_c     = {r_q, q_q[WIDTH-1]};
      ge_c    = (t_c >= {1'b0, d_q});
      diff_c  = t_c[WIDTH-1:0] - d_q;
      r_nxt_c = ge_c ? diff_c : t_c[WIDTH-1:0];
      q_nxt_c = {q_q[WIDTH-2:0], ge_c};
   end

   always_ff @(posedge clk or posedge clr) begin
      if (clr) begin
         state     <= S_IDLE;
         d_q       <= '0;
         q_q       <= '0;
         r_q       <= '0;
         cnt       <= '0;
         busy      <= 1'b0;
         done      <= 1'b0;
         err       <= 1'b0;
         remainder <= '0;
         quotient  <= '0;
      end else begin
         case (state)
            S_IDLE: begin
               if (start) begin
                  d_q   <= divisor;
                  q_q   <= dividend;
                  r_q   <= '0;
                  err   <= 1'b0;
                  busy  <= 1'b1;
                  state <= S_LOAD;
               end
            end
            S_LOAD: begin
               if (d_q == '0) begin
                  err       <= 1'b1;
                  remainder <= q_q;
                  quotient  <= '1;
                  done      <= 1'b1;
                  state     <= S_DONE;
               end else begin
                  cnt   <= CW'(WIDTH - 1);
                  state <= S_RUN;
               end
            end
            S_RUN: begin
               r_q <= r_nxt_c;
               q_q <= q_nxt_c;
               cnt <= cnt - CW'(1);
               if (cnt == '0) begin
                  remainder <= r_nxt_c;
                  quotient  <= q_nxt_c;
                  done      <= 1'b1;
                  state     <= S_DONE;
               end
            end
            S_DONE: begin
               done  <= 1'b0;
               busy  <= 1'b0;
               state <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mod_ctrl.sv
// Self-checking bench for mod_ctrl: directed cases plus randomized operands against
// a plain-arithmetic reference (a % b, a / b, err on b == 0).
module tb_mod_ctrl;

   localparam int unsigned W = 8;

   logic         clk = 1'b0;
   logic         clr;
   logic         start;
   logic [W-1:0] dividend;
   logic [W-1:0] divisor;
   logic         busy;
   logic         done;
   logic         err;
   logic [W-1:0] remainder;
   logic [W-1:0] quotient;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   mod_ctrl #(.WIDTH(W)) dut (
      .clk       (clk),
      .clr       (clr),
      .start     (start),
      .dividend  (dividend),
      .divisor   (divisor),
      .busy      (busy),
      .done      (done),
      .err       (err),
      .remainder (remainder),
      .quotient  (quotient)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   // One operation; optionally scrambles operands and pulses start while busy.
   task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input bit scramble);
      int           lat;
      int           exp_lat;
      logic [W-1:0] er;
      logic [W-1:0] eq;
      logic         ee;
      if (b == 0) begin
         er = a; eq = '1; ee = 1'b1; exp_lat = 2;
      end else begin
         er = a % b; eq = a / b; ee = 1'b0; exp_lat = W + 2;
      end
      @(negedge clk);
      start = 1'b1; dividend = a; divisor = b;
      @(negedge clk);
      start = 1'b0;
      lat = 1;
      check("busy_rise", 32'(busy), 1);
      while (!done && lat < 4 * W) begin
         if (scramble) begin
            dividend = W'($urandom);
            divisor  = W'($urandom);
            start    = 1'($urandom_range(0, 1));
         end
         @(negedge clk);
         lat++;
      end
      start = 1'b0;
      check("done_seen", 32'(done), 1);
      check("latency", 32'(lat), 32'(exp_lat));
      check("remainder", 32'(remainder), 32'(er));
      check("quotient", 32'(quotient), 32'(eq));
      check("err", 32'(err), 32'(ee));
      @(negedge clk);
      check("done_drop", 32'(done), 0);
      check("busy_fall", 32'(busy), 0);
      check("rem_hold", 32'(remainder), 32'(er));
      check("quot_hold", 32'(quotient), 32'(eq));
      check("err_hold", 32'(err), 32'(ee));
   endtask

   initial begin
      int     t;
      int     times[$];
      bit     saw;
      logic [W-1:0] a;
      logic [W-1:0] b;

      clr = 1'b1; start = 1'b0; dividend = '0; divisor = '0;
      repeat (2) @(negedge clk);
      check("rst_busy", 32'(busy), 0);
      check("rst_done", 32'(done), 0);
      check("rst_err", 32'(err), 0);
      check("rst_rem", 32'(remainder), 0);
      check("rst_quot", 32'(quotient), 0);
      clr = 1'b0;

      run_op(8'd200, 8'd7, 1'b0);
      run_op(8'd5, 8'd9, 1'b0);
      run_op(8'd255, 8'd1, 1'b0);
      run_op(8'd42, 8'd0, 1'b0);
      run_op(8'd200, 8'd7, 1'b0);
      run_op(8'd200, 8'd7, 1'b1);

      // clr mid-RUN wipes outputs at once and suppresses done
      run_op(8'd200, 8'd7, 1'b0);
      @(negedge clk);
      start = 1'b1; dividend = 8'd100; divisor = 8'd3;
      @(negedge clk);
      start = 1'b0;
      repeat (3) @(negedge clk);
      #2 clr = 1'b1;
      #1;
      check("clr_busy", 32'(busy), 0);
      check("clr_done", 32'(done), 0);
      check("clr_err", 32'(err), 0);
      check("clr_rem", 32'(remainder), 0);
      check("clr_quot", 32'(quotient), 0);
      @(negedge clk);
      clr = 1'b0;
      saw = 1'b0;
      repeat (15) begin
         @(negedge clk);
         if (done) saw = 1'b1;
      end
      check("no_done_after_clr", 32'(saw), 0);
      run_op(8'd200, 8'd7, 1'b0);

      // start held high: one result every W+3 cycles
      @(negedge clk);
      dividend = 8'd200; divisor = 8'd7; start = 1'b1;
      t = 0;
      repeat (45) begin
         @(negedge clk);
         t++;
         if (done) begin
            times.push_back(t);
            check("held_rem", 32'(remainder), 4);
            check("held_quot", 32'(quotient), 28);
         end
      end
      start = 1'b0;
      check("held_pulses", 32'(times.size()), 4);
      if (times.size() > 0) check("held_first", 32'(times[0]), 32'(W + 2));
      for (int i = 1; i < times.size(); i++)
         check("held_period", 32'(times[i] - times[i-1]), 32'(W + 3));
      repeat (15) @(negedge clk);

      for (int i = 0; i < 500; i++) begin
         a = W'($urandom);
         b = ($urandom_range(0, 7) == 0) ? '0 : W'($urandom);
         run_op(a, b, 1'(i % 2));
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
